// File: rtl/sub_bytes_if.sv
// Block-level stream interface between AddRoundKey-side producer, SubBytes and ShiftRows.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds data until then.
interface sub_bytes_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] block;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] new_block;

  modport master (
    output in_valid, block, out_ready,
    input  in_ready, out_valid, new_block
  );

  modport slave (
    input  in_valid, block, out_ready,
    output in_ready, out_valid, new_block
  );
endinterface

// File: rtl/sub_bytes.sv
// AES SubBytes: one 128-bit state per transaction, substituted BYTES_PER_CYCLE bytes
// per busy cycle through shared S-box lanes that walk the working register in place.
module sub_bytes #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  sub_bytes_if.slave  bus,
  output logic [1:0]  o_dbg_state,
  output logic [4:0]  o_dbg_cnt
);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("sub_bytes: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] STEP = 5'(BYTES_PER_CYCLE);
  localparam logic [4:0] LAST = 5'(16 - BYTES_PER_CYCLE);

  // Forward S-box, row = high nibble, first byte of each row literal = column 0.
  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [127:0] row;
    logic [6:0]   sh;
    row = SBOX_ROWS[x[7:4]];
    sh  = {~x[3:0], 3'b000};
    return row[sh +: 8];
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       r_st;
  state_t       w_st_next;
  logic [4:0]   r_cnt;
  logic [127:0] r_work;
  logic [127:0] w_work_sub;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_accept;

  logic [3:0]   w_pos [BYTES_PER_CYCLE];
  logic [7:0]   w_sub [BYTES_PER_CYCLE];

  // Lane l always handles byte cnt+l; cnt stays <= 16-BYTES_PER_CYCLE while busy.
  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
    assign w_pos[l] = r_cnt[3:0] + 4'(l);
    assign w_sub[l] = sbox(r_work[{w_pos[l], 3'b000} +: 8]);
  end

  always_comb begin
    w_work_sub = r_work;
    for (int l = 0; l < BYTES_PER_CYCLE; l++) begin
      w_work_sub[{w_pos[l], 3'b000} +: 8] = w_sub[l];
    end
  end

  always_comb begin
    w_st_next   = r_st;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_st)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept  = 1'b1;
          w_st_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt == LAST) w_st_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_st_next = S_IDLE;
      end
      default: w_st_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= S_IDLE;
      r_cnt  <= 5'd0;
      r_work <= 128'd0;
    end else begin
      r_st <= w_st_next;
      if (w_accept) begin
        r_work <= bus.block;
        r_cnt  <= 5'd0;
      end else if (r_st == S_BUSY) begin
        r_work <= w_work_sub;
        r_cnt  <= r_cnt + STEP;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.new_block = r_work;
  assign o_dbg_state   = r_st;
  assign o_dbg_cnt     = r_cnt;

endmodule

// File: tb/tb_sub_bytes.sv
// Bench for sub_bytes: arithmetic GF(2^8) S-box reference, scoreboard queue, scenario tasks.
module tb_sub_bytes;

  localparam logic [127:0] FIPS_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZERO_OUT  = 128'h63636363636363636363636363636363;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sub_bytes_if bus ();
  sub_bytes_if bus1 ();
  sub_bytes_if bus16 ();

  logic [1:0] dbg_state, dbg_state1, dbg_state16;
  logic [4:0] dbg_cnt, dbg_cnt1, dbg_cnt16;

  sub_bytes #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state), .o_dbg_cnt(dbg_cnt)
  );
  sub_bytes #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .o_dbg_state(dbg_state1), .o_dbg_cnt(dbg_cnt1)
  );
  sub_bytes #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst(rst), .bus(bus16), .o_dbg_state(dbg_state16), .o_dbg_cnt(dbg_cnt16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   ref_sbox [256];
  logic [127:0] exp_q [$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_ref();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = ref_sbox[b[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Scoreboard bookkeeping for the default-width DUT; called once per negedge after inputs are set.
  task automatic sb_step(output logic acc, output logic fired,
                         output logic [127:0] got, output logic [127:0] exp);
    acc   = !rst && bus.in_valid && bus.in_ready;
    fired = !rst && bus.out_valid && bus.out_ready;
    got   = bus.new_block;
    exp   = 'x;
    if (fired && exp_q.size() != 0) exp = exp_q.pop_front();
    if (acc) exp_q.push_back(model(bus.block));
  endtask

  task automatic test_reset();
    logic a, f;
    logic [127:0] g, e;
    bit done;
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.block = rand_block(); bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.new_block !== 128'd0) begin n_fail++; $display("FAIL reset_new_block: got %h expected 0", bus.new_block); end
    n_tests++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    n_tests++; if (dbg_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", dbg_cnt); end
    bus.block = FIPS_IN;
    rst = 1'b0;
    sb_step(a, f, g, e);
    @(negedge clk);
    n_tests++; if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL reset_release_accept: state %0d expected 1", dbg_state); end
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (k > 0) @(negedge clk);
      bus.in_valid = 1'b0;
      sb_step(a, f, g, e);
      if (f) begin
        done = 1;
        n_tests++; if (g !== FIPS_OUT) begin n_fail++; $display("FAIL reset_release_result: got %h expected %h", g, FIPS_OUT); end
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL reset_release_timeout: no result expected one"); end
  endtask

  task automatic test_vectors();
    logic a, f;
    logic [127:0] g, e;
    logic [127:0] vin [2];
    logic [127:0] vout [2];
    int acc_cyc;
    bit done;
    vin[0] = 128'd0;  vout[0] = ZERO_OUT;
    vin[1] = FIPS_IN; vout[1] = FIPS_OUT;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.block = vin[v]; bus.out_ready = 1'b1;
      sb_step(a, f, g, e);
      acc_cyc = cyc;
      n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL vec%0d_accept: got %b expected 1", v, a); end
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb_step(a, f, g, e);
        if (f) begin
          done = 1;
          n_tests++; if (g !== vout[v]) begin n_fail++; $display("FAIL vec%0d_result: got %h expected %h", v, g, vout[v]); end
          n_tests++; if (cyc - acc_cyc - 1 != 4) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 4", v, cyc - acc_cyc - 1); end
        end
      end
      if (!done) begin n_tests++; n_fail++; $display("FAIL vec%0d_timeout: no result expected one", v); end
    end
  endtask

  task automatic test_exhaustive();
    logic a, f;
    logic [127:0] g, e;
    logic [127:0] blk;
    int sent, got_n;
    sent = 0; got_n = 0;
    for (int k = 0; k < 400 && got_n < 16; k++) begin
      @(negedge clk);
      for (int i = 0; i < 16; i++) blk[8*i +: 8] = 8'(16 * sent + i);
      bus.block = blk; bus.in_valid = (sent < 16); bus.out_ready = 1'b1;
      sb_step(a, f, g, e);
      if (a) sent++;
      if (f) begin
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL exhaustive_blk%0d: got %h expected %h", got_n, g, e); end
        if (got_n == 0) begin
          n_tests++; if (g[15:8] !== 8'h7c) begin n_fail++; $display("FAIL spot_01: got %h expected 7c", g[15:8]); end
        end
        if (got_n == 5) begin
          n_tests++; if (g[31:24] !== 8'hed) begin n_fail++; $display("FAIL spot_53: got %h expected ed", g[31:24]); end
        end
        if (got_n == 15) begin
          n_tests++; if (g[127:120] !== 8'h16) begin n_fail++; $display("FAIL spot_ff: got %h expected 16", g[127:120]); end
        end
        got_n++;
      end
    end
    if (got_n < 16) begin n_tests++; n_fail++; $display("FAIL exhaustive_timeout: got %0d results expected 16", got_n); end
  endtask

  task automatic test_backpressure();
    logic a, f;
    logic [127:0] g, e;
    logic [127:0] blk_a, blk_b, hold;
    bit done;
    blk_a = rand_block(); blk_b = rand_block();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.block = blk_a; bus.out_ready = 1'b0;
    sb_step(a, f, g, e);
    n_tests++; if (a !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b expected 1", a); end
    for (int k = 0; k < 20 && !bus.out_valid; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.block = blk_b;
      sb_step(a, f, g, e);
    end
    if (!bus.out_valid) begin n_tests++; n_fail++; $display("FAIL bp_done_timeout: out_valid 0 expected 1"); end
    hold = bus.new_block;
    n_tests++; if (hold !== model(blk_a)) begin n_fail++; $display("FAIL bp_value: got %h expected %h", hold, model(blk_a)); end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) begin @(negedge clk); sb_step(a, f, g, e); end
      n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d: got %b expected 1", s, bus.out_valid); end
      n_tests++; if (bus.new_block !== hold) begin n_fail++; $display("FAIL bp_stable_c%0d: got %h expected %h", s, bus.new_block, hold); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", s, bus.in_ready); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    sb_step(a, f, g, e);
    n_tests++; if (!(f && g === e)) begin n_fail++; $display("FAIL bp_release: fired %b got %h expected %h", f, g, e); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_no_queue: %0d blocks accepted during stall expected 0", exp_q.size()); end
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (k == 0) bus.in_valid = 1'b1;
      sb_step(a, f, g, e);
      if (f) begin
        done = 1;
        n_tests++; if (g !== model(blk_b)) begin n_fail++; $display("FAIL bp_second: got %h expected %h", g, model(blk_b)); end
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL bp_second_timeout: no result expected one"); end
  endtask

  task automatic test_reset_mid_busy();
    logic a, f;
    logic [127:0] g, e;
    logic [127:0] blk_d;
    bit found, stray, done;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.block = rand_block(); bus.out_ready = 1'b1;
    sb_step(a, f, g, e);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      sb_step(a, f, g, e);
      if (dbg_state == 2'd1 && dbg_cnt == 5'd8) found = 1;
    end
    if (!found) begin n_tests++; n_fail++; $display("FAIL rmb_reach_cnt8: not reached expected cnt 8"); end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmb_in_ready: got %b expected 1", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_out_valid: got %b expected 0", bus.out_valid); end
    n_tests++; if (bus.new_block !== 128'd0) begin n_fail++; $display("FAIL rmb_work_clear: got %h expected 0", bus.new_block); end
    rst = 1'b0;
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      sb_step(a, f, g, e);
      if (bus.out_valid) stray = 1;
    end
    n_tests++; if (stray) begin n_fail++; $display("FAIL rmb_stray_output: got 1 expected 0"); end
    blk_d = rand_block();
    done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      bus.in_valid = (k == 0); bus.block = blk_d;
      sb_step(a, f, g, e);
      if (f) begin
        done = 1;
        n_tests++; if (g !== model(blk_d)) begin n_fail++; $display("FAIL rmb_next_block: got %h expected %h", g, model(blk_d)); end
      end
    end
    if (!done) begin n_tests++; n_fail++; $display("FAIL rmb_next_timeout: no result expected one"); end
  endtask

  task automatic test_back_to_back();
    logic a, f;
    logic [127:0] g, e;
    int sent, got_n, last;
    sent = 0; got_n = 0; last = 0;
    @(negedge clk);
    bus.block = rand_block();
    for (int k = 0; k < 800 && got_n < 100; k++) begin
      if (k > 0) @(negedge clk);
      bus.in_valid = (sent < 100); bus.out_ready = 1'b1;
      sb_step(a, f, g, e);
      if (a) sent++;
      if (f) begin
        n_tests++; if (g !== e) begin n_fail++; $display("FAIL b2b_blk%0d: got %h expected %h", got_n, g, e); end
        if (got_n > 0) begin
          n_tests++; if (cyc - last != 6) begin n_fail++; $display("FAIL b2b_interval%0d: got %0d expected 6", got_n, cyc - last); end
        end
        last = cyc;
        got_n++;
      end
      if (a) begin @(posedge clk); #1 bus.block = rand_block(); end
    end
    if (got_n < 100) begin n_tests++; n_fail++; $display("FAIL b2b_timeout: got %0d results expected 100", got_n); end
  endtask

  task automatic test_sweep_b16();
    logic [127:0] q16 [$];
    logic [127:0] e;
    int sent, got_n, last, first_acc;
    sent = 0; got_n = 0; last = 0; first_acc = 0;
    bus16.block = rand_block();
    for (int k = 0; k < 200 && got_n < 8; k++) begin
      @(negedge clk);
      bus16.in_valid = (sent < 8); bus16.out_ready = 1'b1;
      if (bus16.out_valid) begin
        e = 'x;
        if (q16.size() != 0) e = q16.pop_front();
        n_tests++; if (bus16.new_block !== e) begin n_fail++; $display("FAIL b16_blk%0d: got %h expected %h", got_n, bus16.new_block, e); end
        if (got_n == 0) begin
          n_tests++; if (cyc - first_acc - 1 != 1) begin n_fail++; $display("FAIL b16_latency: got %0d expected 1", cyc - first_acc - 1); end
        end else begin
          n_tests++; if (cyc - last != 3) begin n_fail++; $display("FAIL b16_interval%0d: got %0d expected 3", got_n, cyc - last); end
        end
        last = cyc;
        got_n++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        if (sent == 0) first_acc = cyc;
        q16.push_back(model(bus16.block));
        sent++;
        @(posedge clk); #1 bus16.block = rand_block();
      end
    end
    bus16.in_valid = 1'b0;
    if (got_n < 8) begin n_tests++; n_fail++; $display("FAIL b16_timeout: got %0d results expected 8", got_n); end
  endtask

  task automatic test_sweep_b1();
    logic [127:0] q1 [$];
    logic [127:0] e;
    int sent, got_n, last, first_acc;
    sent = 0; got_n = 0; last = 0; first_acc = 0;
    bus1.block = rand_block();
    for (int k = 0; k < 400 && got_n < 6; k++) begin
      @(negedge clk);
      bus1.in_valid = (sent < 6); bus1.out_ready = 1'b1;
      if (bus1.out_valid) begin
        e = 'x;
        if (q1.size() != 0) e = q1.pop_front();
        n_tests++; if (bus1.new_block !== e) begin n_fail++; $display("FAIL b1_blk%0d: got %h expected %h", got_n, bus1.new_block, e); end
        if (got_n == 0) begin
          n_tests++; if (cyc - first_acc - 1 != 16) begin n_fail++; $display("FAIL b1_latency: got %0d expected 16", cyc - first_acc - 1); end
        end else begin
          n_tests++; if (cyc - last != 18) begin n_fail++; $display("FAIL b1_interval%0d: got %0d expected 18", got_n, cyc - last); end
        end
        last = cyc;
        got_n++;
      end
      if (bus1.in_valid && bus1.in_ready) begin
        if (sent == 0) first_acc = cyc;
        q1.push_back(model(bus1.block));
        sent++;
        @(posedge clk); #1 bus1.block = rand_block();
      end
    end
    bus1.in_valid = 1'b0;
    if (got_n < 6) begin n_tests++; n_fail++; $display("FAIL b1_timeout: got %0d results expected 6", got_n); end
  endtask

  initial begin
    bus.in_valid = 1'b0;   bus.block = '0;   bus.out_ready = 1'b1;
    bus1.in_valid = 1'b0;  bus1.block = '0;  bus1.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.block = '0; bus16.out_ready = 1'b1;
    build_ref();
    test_reset();
    test_vectors();
    test_exhaustive();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
    test_sweep_b16();
    test_sweep_b1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
